majority_vote_ctrl: RTL and testbench
=====================================

MAJORITY_VOTE_CTRL -- requirements
Module: majority_vote_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of voters (N >= 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of COLLECT cycles per round (TIMEOUT >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: opens a voting round.
REQ-006 The block SHALL have port vote_valid, input, 1 bit: a ballot is presented.
REQ-007 The block SHALL have port vote_id, input, $clog2(N) bits: the voter index of the ballot.
REQ-008 The block SHALL have port vote_val, input, 1 bit: the ballot value.
REQ-009 The block SHALL have port vote_ready, output, 1 bit: the block is able to accept a ballot.
REQ-010 The block SHALL have port busy, output, 1 bit: a round is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 The block SHALL have port F, output, 1 bit: the majority result.
REQ-013 The block SHALL have port tally, output, $clog2(N+1) bits: the count of accepted 1-ballots.
REQ-014 The block SHALL have port timed_out, output, 1 bit: the last round ended by timeout.
REQ-015 The block SHALL have port vote_err, output, 1 bit: one-cycle pulse when a ballot is rejected.

Function
REQ-016 The FSM SHALL have the states IDLE, COLLECT, DECIDE and DONE.
REQ-017 In IDLE, start=1 SHALL clear the ballot register, voted mask and timer, and move the FSM to COLLECT next cycle; start SHALL be ignored in every other state.
REQ-018 vote_ready SHALL be 1 only in COLLECT; a ballot is accepted on a cycle with vote_valid && vote_ready.
REQ-019 An accepted ballot with vote_id < N and voted[vote_id]=0 SHALL set voted[vote_id] and ballot[vote_id]=vote_val.
REQ-020 An accepted ballot with voted[vote_id]=1 or vote_id >= N SHALL leave state unchanged and pulse vote_err the next cycle.
REQ-021 The timer SHALL increment on every COLLECT cycle.
REQ-022 COLLECT SHALL go to DECIDE when the voted mask becomes all ones (the cycle after the last valid ballot), or when the timer reaches TIMEOUT-1 without the mask being full.
REQ-023 On the timeout exit, timed_out SHALL be set to 1; otherwise timed_out SHALL be set to 0.
REQ-024 If the last missing ballot is accepted on the timer-expiry cycle, the ballot SHALL count and timed_out SHALL remain 0.
REQ-025 Voters that have not voted SHALL count as 0.
REQ-026 In DECIDE, F SHALL be registered as (count of ones > N/2) using integer division, so a tie gives 0, and tally SHALL be registered as the count of ones.
REQ-027 DECIDE SHALL last 1 cycle and move to DONE.
REQ-028 DONE SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-029 F, tally and timed_out SHALL hold their values until the next DECIDE.
REQ-030 busy SHALL be 1 in COLLECT, DECIDE and DONE.
REQ-031 Latency SHALL be: done high 2 cycles after the cycle the last ballot is accepted.

Reset
REQ-032 Asserting rst_n=0 SHALL, at any time including mid-round, force IDLE and clear ballot, voted and timer.
REQ-033 Reset SHALL drive F=0, tally=0, timed_out=0, done=0, vote_err=0, vote_ready=0 and busy=0.
REQ-034 After rst_n deasserts, the block SHALL require a new start; no partial round resumes.

Structure
REQ-035 State encodings (IDLE=0, COLLECT=1, DECIDE=2, DONE=3) SHALL live in shared package majority_pkg, alongside width helper constants for tally and the timer.
REQ-036 Majority evaluation SHALL be one instance of majority_n_bit #(N) driven by ballot & voted.
REQ-037 tally SHALL be computed by a separate popcount in this block.

Verification (N=4, TIMEOUT=16)
REQ-038 Stimulus: start, then ballots id0..3 = 1,1,1,0 on consecutive cycles -> required: done 2 cycles after id3, F=1, tally=3, timed_out=0.
REQ-039 Stimulus: ballots 1,1,0,0 -> required: F=0 (tie), tally=2.
REQ-040 Stimulus: id2=1 then id2=0 -> required: vote_err pulses once, ballot[2] remains 1; also id=3 re-vote after acceptance -> vote_err pulses.
REQ-041 Stimulus: only id0=1 and id1=1 sent -> required: DECIDE at the 16th COLLECT cycle, timed_out=1, F=0, tally=2.
REQ-042 Stimulus: last ballot arrives on COLLECT cycle 16 -> required: timed_out=0, ballot counted.
REQ-043 Stimulus: rst_n pulsed low mid-COLLECT after 2 ballots -> required: all outputs 0 immediately, vote_ready=0, start needed; next round unaffected by old ballots.

Source files
------------

// File: rtl/majority_pkg.sv
// majority_pkg: FSM state encodings and width helpers shared by the majority vote controller
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int tally_w(input int n);
        return $clog2(n + 1);
    endfunction

    // A one-cycle window still needs a 1-bit timer.
    function automatic int timer_w(input int t);
        return t < 2 ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/majority_n_bit.sv
// majority_n_bit: f is 1 when strictly more than half of the N inputs are 1 (a tie gives 0)
module majority_n_bit #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    output logic         f
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF = CW'(N / 2);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + CW'(x[i]);
        f = cnt > HALF;
    end

endmodule

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: collects one ballot per voter within a bounded window and
// reports the majority result, the count of 1-ballots and whether the window expired.
module majority_vote_ctrl import majority_pkg::*; #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       vote_valid,
    input  logic [$clog2(N)-1:0]       vote_id,
    input  logic                       vote_val,
    output logic                       vote_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       F,
    output logic [$clog2(N+1)-1:0]     tally,
    output logic                       timed_out,
    output logic                       vote_err
);
    localparam int TW = tally_w(N);
    localparam int MW = timer_w(TIMEOUT);
    localparam logic [MW-1:0] LAST = MW'(TIMEOUT - 1);

    state_t        state;
    logic [N-1:0]  ballot, voted, voted_nxt, sel, cast_ones;
    logic [MW-1:0] timer;
    logic [TW-1:0] ones;
    logic          maj, take, fresh, bad, full_nxt, expire;

    majority_n_bit #(.N(N)) u_maj (.x(cast_ones), .f(maj));

    // An out-of-range id shifts the one-hot past the top bit, so sel is zero and the ballot is rejected.
    always_comb begin
        sel       = N'(1) << vote_id;
        take      = state == COLLECT && vote_valid;
        fresh     = take && |(sel & ~voted);
        bad       = take && !fresh;
        voted_nxt = fresh ? voted | sel : voted;
        full_nxt  = &voted_nxt;
        expire    = timer == LAST;
        cast_ones = ballot & voted;
        ones      = '0;
        for (int i = 0; i < N; i++) ones = ones + TW'(cast_ones[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ballot     <= '0;
            voted      <= '0;
            timer      <= '0;
            vote_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            F          <= 1'b0;
            tally      <= '0;
            timed_out  <= 1'b0;
            vote_err   <= 1'b0;
        end else begin
            vote_err <= bad;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ballot     <= '0;
                    voted      <= '0;
                    timer      <= '0;
                    vote_ready <= 1'b1;
                    busy       <= 1'b1;
                    state      <= COLLECT;
                end
                COLLECT: begin
                    voted  <= voted_nxt;
                    ballot <= fresh ? (ballot & ~sel) | (sel & {N{vote_val}}) : ballot;
                    timer  <= timer + MW'(1);
                    // A ballot that fills the mask on the expiry cycle wins over the timeout.
                    if (full_nxt || expire) begin
                        timed_out  <= !full_nxt;
                        vote_ready <= 1'b0;
                        state      <= DECIDE;
                    end
                end
                DECIDE: begin
                    F     <= maj;
                    tally <= ones;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl: directed rounds; expected results and error pulses are queued
// by the driver and matched by a monitor whenever done or vote_err is seen.
module tb_majority_vote_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, vote_valid = 1'b0, vote_val = 1'b0;
    logic [1:0] vote_id = '0;
    logic       vote_ready, busy, done, F, timed_out, vote_err;
    logic [2:0] tally;

    int checks = 0, errors = 0, cyc = 0, acc = 0, s = 0;

    typedef struct {int f; int t; int to; int c;} exp_t;
    exp_t sb[$];
    int   err_q[$];
    exp_t me;
    int   mc;

    majority_vote_ctrl #(.N(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_val(vote_val), .vote_ready(vote_ready), .busy(busy),
        .done(done), .F(F), .tally(tally), .timed_out(timed_out), .vote_err(vote_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected done", 32'(done), 0);
            else begin
                me = sb.pop_front();
                chk("F", 32'(F), me.f);
                chk("tally", 32'(tally), me.t);
                chk("timed_out", 32'(timed_out), me.to);
                chk("done cycle", cyc, me.c);
            end
        end
        if (vote_err === 1'b1) begin
            if (err_q.size() == 0) chk("unexpected vote_err", 32'(vote_err), 0);
            else begin
                mc = err_q.pop_front();
                chk("vote_err cycle", cyc, mc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        s = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic send(input int id, input logic v);
        vote_valid = 1'b1;
        vote_id = 2'(id);
        vote_val = v;
        acc = cyc;
        step(1);
        vote_valid = 1'b0;
    endtask

    task automatic expect_res(input int f, input int t, input int to, input int c);
        sb.push_back('{f, t, to, c});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || err_q.size() != 0) && n < 40) begin
            step(1);
            n++;
        end
        chk("pending expectations", sb.size() + err_q.size(), 0);
        sb.delete();
        err_q.delete();
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("reset outputs", {F, tally, timed_out, done, vote_err, vote_ready, busy}, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle vote_ready", 32'(vote_ready), 0);

        // 1,1,1,0 -> majority
        do_start();
        chk("collect vote_ready", 32'(vote_ready), 1);
        chk("collect busy", 32'(busy), 1);
        send(0, 1); send(1, 1); send(2, 1); send(3, 0);
        expect_res(1, 3, 0, acc + 2);
        drain();
        chk("busy after round", 32'(busy), 0);
        chk("F holds", 32'(F), 1);

        // 1,1,0,0 -> tie gives 0
        do_start();
        send(0, 1); send(1, 1); send(2, 0); send(3, 0);
        expect_res(0, 2, 0, acc + 2);
        drain();

        // re-votes rejected; first ballot for id2 and id3 stands
        do_start();
        send(2, 1);
        err_q.push_back(cyc + 1);
        send(2, 0);
        send(3, 1);
        err_q.push_back(cyc + 1);
        send(3, 0);
        send(0, 1); send(1, 0);
        expect_res(1, 3, 0, acc + 2);
        drain();

        // only two ballots -> timeout after 16 COLLECT cycles
        do_start();
        send(0, 1); send(1, 1);
        expect_res(0, 2, 1, s + 18);
        drain();
        chk("timed_out holds", 32'(timed_out), 1);

        // last ballot on the 16th COLLECT cycle still counts
        do_start();
        send(0, 1); send(1, 1); send(2, 0);
        step(s + 16 - cyc);
        send(3, 1);
        expect_res(1, 3, 0, s + 18);
        drain();
        chk("timed_out cleared", 32'(timed_out), 0);

        // async reset mid-round
        do_start();
        send(0, 1); send(1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset outputs", {F, tally, timed_out, done, vote_err, vote_ready, busy}, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        vote_valid = 1'b1; vote_id = 2'd2; vote_val = 1'b1;
        step(2);
        vote_valid = 1'b0;
        chk("no resume vote_ready", 32'(vote_ready), 0);
        chk("no resume busy", 32'(busy), 0);
        do_start();
        send(0, 0); send(1, 0); send(2, 1); send(3, 0);
        expect_res(0, 1, 0, acc + 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
